// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: serialises single-beat writes and burst reads onto a single-port RAM.
// Optional build macro RAM_CTRL_INIT_EN: zero-fill the whole RAM after every reset release.
module ram_access_ctrl #(
   parameter int ADDRWIDTH = 4,
   parameter int DATAWIDTH = 8,
   parameter int SIZE      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDRWIDTH-1:0] req_addr,
   input  logic [DATAWIDTH-1:0] req_wdata,
   input  logic [ADDRWIDTH-1:0] req_len,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATAWIDTH-1:0] rsp_data,
   output logic                 rsp_last,
   output logic [ADDRWIDTH-1:0] ram_addr,
   output logic [DATAWIDTH-1:0] ram_data,
   output logic                 ram_cs,
   output logic                 ram_we,
   input  logic [DATAWIDTH-1:0] ram_dout
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WR       = 3'd1;
   localparam logic [2:0] RD_ISSUE = 3'd2;
   localparam logic [2:0] RD_WAIT  = 3'd3;
   localparam logic [2:0] RD_RESP  = 3'd4;
   localparam logic [ADDRWIDTH-1:0] LAST = ADDRWIDTH'(SIZE - 1);
`ifdef RAM_CTRL_INIT_EN
   localparam logic [2:0] INIT      = 3'd5;
   localparam logic [2:0] RST_STATE = INIT;
`else
   localparam logic [2:0] RST_STATE = IDLE;
`endif

   logic [2:0]           state, state_n;
   logic [ADDRWIDTH-1:0] addr, addr_n, addr_inc, cnt, cnt_n;
   logic                 init_n, strobe_n, write_n;

   assign req_ready = state == IDLE;
   assign addr_inc  = (addr == LAST) ? '0 : addr + ADDRWIDTH'(1);

`ifdef RAM_CTRL_INIT_EN
   // The sweep ends once the strobe for the last address is on the bus, so
   // req_ready stays low for every zero-fill strobe.
   logic init_last;
   assign init_last = ram_cs && ram_addr == LAST;
   assign init_n    = state == INIT && !init_last;
`else
   assign init_n    = 1'b0;
`endif

   // RAM strobes are registered from the state being entered (or the sweep address).
   assign strobe_n = state_n == WR || state_n == RD_ISSUE || init_n;
   assign write_n  = state_n == WR || init_n;

   // Next-state, address and beat-counter logic.
   always_comb begin
      state_n = state;
      addr_n  = addr;
      cnt_n   = cnt;
      case (state)
         IDLE: if (req_valid) begin
            state_n = req_we ? WR : RD_ISSUE;
            addr_n  = req_addr;
            cnt_n   = req_len;
         end
         WR:       state_n = IDLE;
         RD_ISSUE: state_n = RD_WAIT;
         RD_WAIT:  state_n = RD_RESP;
         RD_RESP: if (rsp_ready) begin
            state_n = (cnt == '0) ? IDLE : RD_ISSUE;
            addr_n  = (cnt == '0) ? addr : addr_inc;
            cnt_n   = (cnt == '0) ? cnt : cnt - ADDRWIDTH'(1);
         end
`ifdef RAM_CTRL_INIT_EN
         INIT: begin
            addr_n  = addr_inc;
            state_n = init_last ? IDLE : INIT;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   // State plus registered RAM and response outputs; reset aborts everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RST_STATE;
         addr      <= '0;
         cnt       <= '0;
         ram_cs    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_data  <= '0;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_data  <= '0;
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         cnt       <= cnt_n;
         ram_cs    <= strobe_n;
         ram_we    <= write_n;
         if (strobe_n) ram_addr <= init_n ? addr : addr_n;
         if (write_n) ram_data <= init_n ? '0 : req_wdata;
         if (state == RD_WAIT) rsp_data <= ram_dout;
         rsp_valid <= state_n == RD_RESP;
         rsp_last  <= state_n == RD_RESP && cnt_n == '0;
      end
   end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed bench for ram_access_ctrl with a behavioural single-port RAM.
module tb_ram_access_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_ready, req_we;
   logic [3:0] req_addr, req_len;
   logic [7:0] req_wdata;
   logic       rsp_valid, rsp_ready, rsp_last;
   logic [7:0] rsp_data;
   logic [3:0] ram_addr;
   logic [7:0] ram_data, ram_dout;
   logic       ram_cs, ram_we;
   logic [7:0] mem [16];
   logic [7:0] exp_q [$];
   int         checks = 0;
   int         errors = 0;
   int         k;
`ifdef RAM_CTRL_INIT_EN
   localparam logic RR = 1'b0;
`else
   localparam logic RR = 1'b1;
`endif

   ram_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_cs(ram_cs), .ram_we(ram_we),
      .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM: read data appears the cycle after the strobe.
   always_ff @(posedge clk) begin
      if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
      if (ram_cs && !ram_we) ram_dout <= mem[ram_addr];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_last"}, rsp_last, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_ram_cs"}, ram_cs, 0);
      chk({tag, "_ram_we"}, ram_we, 0);
      chk({tag, "_ram_addr"}, ram_addr, 0);
      chk({tag, "_ram_data"}, ram_data, 0);
      chk({tag, "_req_ready"}, req_ready, RR);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      req_valid = 1; req_we = 1; req_addr = a; req_wdata = d;
      chk("wr_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 0;
      chk("wr_cs", ram_cs, 1);
      chk("wr_we", ram_we, 1);
      chk("wr_addr", ram_addr, a);
      chk("wr_data", ram_data, d);
      @(negedge clk);
      chk("wr_cs_off", ram_cs, 0);
   endtask

   // Burst read checked against exp_q; optional stall beat, busy-time request noise, or reset abort.
   task automatic rd(input logic [3:0] a, input logic [3:0] len, input int stall_beat,
                     input logic noise, input int rst_beat);
      logic [7:0] held;
      int n;
      req_valid = 1; req_we = 0; req_addr = a; req_len = len;
      chk("rd_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 0;
      chk("rd_cs", ram_cs, 1);
      chk("rd_we", ram_we, 0);
      chk("rd_addr", ram_addr, a);
      for (int b = 0; b <= int'(len); b++) begin
         n = 0;
         while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("wait_cs", ram_cs, 0);
            if (b == rst_beat && n == 1) begin
               rst_n = 0;
               #1;
               chk_reset_values("abort");
               return;
            end
            if (noise) begin
               req_valid = 1; req_we = 1; req_addr = 4'd6; req_wdata = 8'h90 + 8'(n);
               chk("busy_ready", req_ready, 0);
            end
         end
         chk("beat_gap", n, 2);
         chk("beat_data", rsp_data, exp_q[b]);
         chk("beat_last", rsp_last, b == int'(len));
         if (b == stall_beat) begin
            rsp_ready = 0;
            held = rsp_data;
            repeat (5) begin
               @(negedge clk);
               chk("stall_valid", rsp_valid, 1);
               chk("stall_data", rsp_data, held);
               chk("stall_cs", ram_cs, 0);
            end
            rsp_ready = 1;
         end
         if (noise && b == int'(len)) begin
            req_addr = 4'd5; req_wdata = 8'h77;
         end
         @(negedge clk);
         if (noise && b != int'(len)) chk("busy_ready", req_ready, 0);
      end
      chk("rsp_done", rsp_valid, 0);
   endtask

   initial begin
      rst_n = 0; req_valid = 0; req_we = 0; req_addr = 0; req_len = 0; req_wdata = 0; rsp_ready = 1;
      #3;
      chk_reset_values("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
`ifdef RAM_CTRL_INIT_EN
      n_init();
      exp_q = '{16{8'h00}};
      rd(4'd0, 4'd15, -1, 0, -1);
`endif
      // single write then single-beat read
      wr(4'd3, 8'hA5);
      exp_q = '{8'hA5};
      rd(4'd3, 4'd0, -1, 0, -1);
      // fill, then wrapping burst
      for (int i = 0; i < 16; i++) wr(4'(i), 8'h10 + 8'(i));
      exp_q = '{8'h1E, 8'h1F, 8'h10, 8'h11};
      rd(4'd14, 4'd3, -1, 0, -1);
      // same burst with beat 2 back-pressured
      rd(4'd14, 4'd3, 1, 0, -1);
      // requests offered while busy are ignored; the one present at IDLE is taken
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
      rd(4'd0, 4'd3, -1, 1, -1);
      chk("post_busy_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 0;
      chk("post_busy_cs", ram_cs, 1);
      chk("post_busy_we", ram_we, 1);
      chk("post_busy_addr", ram_addr, 5);
      chk("post_busy_data", ram_data, 8'h77);
      @(negedge clk);
      exp_q = '{8'h77, 8'h16};
      rd(4'd5, 4'd1, -1, 0, -1);
      // reset during RD_WAIT of beat 2
      exp_q = '{8'h1E, 8'h1F, 8'h10, 8'h11};
      rd(4'd14, 4'd3, -1, 0, 1);
      @(negedge clk);
      chk_reset_values("held");
      rst_n = 1;
      chk("release_ready", req_ready, RR);
`ifdef RAM_CTRL_INIT_EN
      n_init();
`endif
      repeat (4) begin
         @(negedge clk);
         chk("no_stale", rsp_valid, 0);
      end
      wr(4'd9, 8'h3C);
      exp_q = '{8'h3C};
      rd(4'd9, 4'd0, -1, 0, -1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

`ifdef RAM_CTRL_INIT_EN
   // Count zero-fill strobes after reset release until req_ready rises.
   task automatic n_init();
      int cnt = 0;
      k = 0;
      while (!req_ready && k < 40) begin
         @(negedge clk);
         k++;
         chk("init_no_rsp", rsp_valid, 0);
         if (ram_cs) begin
            chk("init_we", ram_we, 1);
            chk("init_data", ram_data, 0);
            chk("init_addr", ram_addr, cnt);
            chk("init_ready", req_ready, 0);
            cnt++;
         end
      end
      chk("init_strobes", cnt, 16);
      chk("init_done", req_ready, 1);
   endtask
`endif
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Request sequencer that sits directly upstream of `single_port_ram` and owns its `addr`/`data`/`cs`/`we` inputs. It accepts single-beat write requests and burst read requests over a valid/ready handshake. It drives one RAM access at a time and returns read data over a valid/ready response channel with a last-beat flag. It also serialises RAM access, so that the RAM never sees a collision.

## Interface
Parameters:
- `ADDRWIDTH`, 4, RAM address width.
- `DATAWIDTH`, 8, RAM data width.
- `SIZE`, 16, RAM depth. Must equal 2**ADDRWIDTH.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDRWIDTH  start address.
- `req_wdata`  in  DATAWIDTH  write data (writes only).
- `req_len`  in  ADDRWIDTH  read beats minus 1; ignored for writes.
- `rsp_valid`  out  1  read data beat present.
- `rsp_ready`  in  1  beat consumed when `rsp_valid && rsp_ready`.
- `rsp_data`  out  DATAWIDTH  read data.
- `rsp_last`  out  1  final beat of the burst.
- `ram_addr`  out  ADDRWIDTH  to RAM `addr`.
- `ram_data`  out  DATAWIDTH  to RAM `data`.
- `ram_cs`  out  1  to RAM `cs`.
- `ram_we`  out  1  to RAM `we`.
- `ram_dout`  in  DATAWIDTH  from RAM `dataOut`. Valid the cycle after a read strobe.

## Operation
- FSM states: INIT (macro only), IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP.
- `req_ready` = (state == IDLE). Requests are captured (addr, wdata, len, we) only on a handshake. `req_valid` in any other state is ignored and not queued.
- IDLE -> WR on a write handshake.
- WR, one cycle: `ram_cs`=1, `ram_we`=1, `ram_addr`/`ram_data` = captured values. WR -> IDLE.
- IDLE -> RD_ISSUE on a read handshake. The beat counter loads `req_len`.
- RD_ISSUE, one cycle: `ram_cs`=1, `ram_we`=0, `ram_addr` = current address. RD_ISSUE -> RD_WAIT.
- RD_WAIT, one cycle: `ram_cs`=0. `ram_dout` is registered into `rsp_data` at the end of the cycle. RD_WAIT -> RD_RESP.
- RD_RESP: `rsp_valid`=1. `rsp_data` is held stable while `rsp_ready`=0. `rsp_last`=1 when the counter is 0.
  - On a response handshake with counter 0: go to IDLE.
  - Otherwise: address += 1 (mod SIZE, so SIZE-1 wraps to 0), counter -= 1, go to RD_ISSUE.
- `ram_cs`/`ram_we` are 0 in every state not listed as driving them. `ram_addr`/`ram_data` hold their last values.
- Reset asserted at any time aborts the operation immediately. Any in-flight burst is dropped, with no partial response and no pending write.

## Timing
- Reset values: `rsp_valid`=0, `rsp_last`=0, `rsp_data`=0, `ram_cs`=0, `ram_we`=0, `ram_addr`=0, `ram_data`=0.
- `req_ready` reset value: 1 without the macro, 0 with it.
- Write: the handshake is in cycle N. The RAM strobe is in cycle N+1. `req_ready` is high again in N+2, so the peak rate is 1 write per 2 cycles.
- Read: the handshake is in cycle N. The strobe is in N+1. `rsp_valid` first rises in N+3.
- Each further read beat takes 3 cycles after the previous response handshake (RD_ISSUE, RD_WAIT, RD_RESP).
- `req_len` = SIZE-1 reads the whole RAM once, wrapping from the start address.
- All outputs are registered; there are no combinational paths from input to output except `req_ready` from state.

## Configuration
- `RAM_CTRL_INIT_EN` defined:
  - On reset release, the FSM starts in INIT and writes 0 to addresses 0..SIZE-1, one per cycle (`ram_cs`=`ram_we`=1, `ram_data`=0).
  - `req_ready` stays 0 for those SIZE cycles. The FSM then enters IDLE.
  - Reset during INIT restarts the sweep from address 0.
- Not defined: the INIT state and its counter are absent. The FSM resets into IDLE and RAM contents are undefined until written.

## Test plan
- Write 0xA5 to address 3, then read address 3 with `req_len`=0 -> one beat, `rsp_data`=0xA5, `rsp_last`=1, first `rsp_valid` 3 cycles after the read handshake.
- Write 0x10..0x1F to addresses 0..15, then read from address 14 with `req_len`=3 -> beats 0x1E, 0x1F, 0x10, 0x11; `rsp_last` on the 4th beat only.
- Same burst with `rsp_ready` held low 5 cycles on beat 2 -> `rsp_data` stable throughout, no extra RAM strobes, beat order unchanged.
- `req_valid` held high with differing payloads during a 4-beat burst -> `req_ready`=0, the payloads are not captured, and the next accepted request is the one present when IDLE returns.
- Assert `rst_n` low in RD_WAIT of beat 2 -> all outputs take reset values asynchronously; after release no stale beat appears and `req_ready` follows the macro setting.
- With `RAM_CTRL_INIT_EN`: release reset, count 16 write strobes with data 0 at addresses 0..15 while `req_ready`=0, then read all 16 -> every beat = 0x00.
